// File: rtl/fs4_mix18.sv
// fs/4 quadrature mixer: rotates (I,Q) by (-j)^n or (+j)^n with true-negation saturation.
// Latency 2 cycles, one sample per cycle, no backpressure (EN is a pure strobe).
module fs4_mix18 #(
  parameter bit SATEN = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic        SYNC,
  input  logic        DIR,
  input  logic [17:0] IIN,
  input  logic [17:0] QIN,
  output logic [17:0] IOUT,
  output logic [17:0] QOUT,
  output logic        VOUT,
  output logic        SAT,
  output logic [1:0]  PH
);

  logic [1:0]  n;
  logic [1:0]  p;
  logic [1:0]  pe;
  logic [17:0] op_i;
  logic [17:0] op_q;
  logic        ci;
  logic        cq;

  logic        s1_vld;
  logic [17:0] s1_i;
  logic [17:0] s1_q;
  logic        s1_ci;
  logic        s1_cq;

  logic [18:0] fin_i;
  logic [18:0] fin_q;

  // Completes a ones-complement negation; {sat, value}. Only ~0x20000 = 0x1FFFF overflows.
  function automatic logic [18:0] finish_neg(input logic [17:0] v, input logic c);
    logic [17:0] sum;
    sum = v + {17'd0, c};
    if (c && (v == 18'h1FFFF)) begin
      if (SATEN) return {1'b1, 18'h1FFFF};
      return {1'b0, 18'h20000};
    end
    return {1'b0, sum};
  endfunction

  // The up-shift sequence is the down-shift sequence run with phase -n.
  always_comb begin
    p    = SYNC ? 2'd0 : n;
    pe   = DIR ? (~p + 2'd1) : p;
    op_i = pe[0] ? QIN : IIN;
    op_q = pe[0] ? IIN : QIN;
    ci   = pe[1];
    cq   = pe[1] ^ pe[0];
  end

  always_comb begin
    fin_i = finish_neg(s1_i, s1_ci);
    fin_q = finish_neg(s1_q, s1_cq);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      n      <= 2'd0;
      s1_vld <= 1'b0;
      s1_i   <= 18'd0;
      s1_q   <= 18'd0;
      s1_ci  <= 1'b0;
      s1_cq  <= 1'b0;
      IOUT   <= 18'd0;
      QOUT   <= 18'd0;
      VOUT   <= 1'b0;
      SAT    <= 1'b0;
    end else begin
      s1_vld <= EN;
      if (EN) begin
        n     <= p + 2'd1;
        s1_i  <= ci ? ~op_i : op_i;
        s1_q  <= cq ? ~op_q : op_q;
        s1_ci <= ci;
        s1_cq <= cq;
      end else if (SYNC) begin
        n <= 2'd0;
      end
      VOUT <= s1_vld;
      SAT  <= s1_vld & (fin_i[18] | fin_q[18]);
      if (s1_vld) begin
        IOUT <= fin_i[17:0];
        QOUT <= fin_q[17:0];
      end
    end
  end

  assign PH = n;

endmodule

// File: tb/tb_fs4_mix18.sv
// Directed and randomized checks of fs4_mix18 with SATEN=1 and SATEN=0 instances.
module tb_fs4_mix18;

  logic        clk;
  logic        rst;
  logic        en;
  logic        sync;
  logic        dir;
  logic [17:0] iin;
  logic [17:0] qin;
  logic [17:0] iout;
  logic [17:0] qout;
  logic        vout;
  logic        sat;
  logic [1:0]  ph;
  logic [17:0] iout0;
  logic [17:0] qout0;
  logic        vout0;
  logic        sat0;
  logic [1:0]  ph0;

  int errors = 0;
  int checks = 0;

  fs4_mix18 dut (
    .CLK(clk), .RST(rst), .EN(en), .SYNC(sync), .DIR(dir), .IIN(iin), .QIN(qin),
    .IOUT(iout), .QOUT(qout), .VOUT(vout), .SAT(sat), .PH(ph)
  );

  fs4_mix18 #(.SATEN(1'b0)) dut0 (
    .CLK(clk), .RST(rst), .EN(en), .SYNC(sync), .DIR(dir), .IIN(iin), .QIN(qin),
    .IOUT(iout0), .QOUT(qout0), .VOUT(vout0), .SAT(sat0), .PH(ph0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; sync = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; sync = 1'b1; dir = 1'b0;
    iin = 18'd1234; qin = 18'd4321;
    step();
    step();
    checks++;
    if ({iout, qout, vout, sat, ph} !== 40'd0) begin
      errors++;
      $display("FAIL reset_sat1: got i=%h q=%h v=%b s=%b ph=%0d, want all 0", iout, qout, vout, sat, ph);
    end
    checks++;
    if ({iout0, qout0, vout0, sat0, ph0} !== 40'd0) begin
      errors++;
      $display("FAIL reset_sat0: got i=%h q=%h v=%b s=%b ph=%0d, want all 0", iout0, qout0, vout0, sat0, ph0);
    end
    rst = 1'b0; en = 1'b0; sync = 1'b0;
  endtask

  task automatic test_mapping(input logic d);
    int ei[4];
    int eq[4];
    if (d == 1'b0) begin
      ei = '{1000, 200, -1000, -200};
      eq = '{200, -1000, -200, 1000};
    end else begin
      ei = '{1000, -200, -1000, 200};
      eq = '{200, 1000, -200, -1000};
    end
    do_reset();
    dir = d; iin = 18'(1000); qin = 18'(200);
    for (int c = 0; c < 6; c++) begin
      en = (c < 4);
      step();
      checks++;
      if (c >= 1 && c <= 4) begin
        if (vout !== 1'b1 || iout !== 18'(ei[c-1]) || qout !== 18'(eq[c-1]) || sat !== 1'b0) begin
          errors++;
          $display("FAIL map dir=%0d c=%0d: got v=%b i=%0d q=%0d s=%b, want v=1 i=%0d q=%0d s=0",
                   d, c, vout, $signed(iout), $signed(qout), sat, ei[c-1], eq[c-1]);
        end
      end else if (vout !== 1'b0) begin
        errors++;
        $display("FAIL map_idle dir=%0d c=%0d: got v=%b, want 0", d, c, vout);
      end
    end
    checks++;
    if (ph !== 2'd0) begin
      errors++;
      $display("FAIL map_ph dir=%0d: got %0d, want 0", d, ph);
    end
  endtask

  task automatic test_saturation();
    int si[4], sq[4], ei[4], eq[4], wi[4], wq[4];
    logic es[4];
    si = '{7, 131071, -131072, 9};
    sq = '{-3, 5, -131072, 0};
    ei = '{7, 5, 131071, 0};
    eq = '{-3, -131071, 131071, 9};
    es = '{1'b0, 1'b0, 1'b1, 1'b0};
    wi = '{7, 5, -131072, 0};
    wq = '{-3, -131071, -131072, 9};
    do_reset();
    dir = 1'b0;
    for (int c = 0; c < 6; c++) begin
      en = (c < 4);
      if (c < 4) begin iin = 18'(si[c]); qin = 18'(sq[c]); end
      step();
      if (c >= 1 && c <= 4) begin
        checks++;
        if (vout !== 1'b1 || iout !== 18'(ei[c-1]) || qout !== 18'(eq[c-1]) || sat !== es[c-1]) begin
          errors++;
          $display("FAIL sat_on c=%0d: got v=%b i=%0d q=%0d s=%b, want v=1 i=%0d q=%0d s=%b",
                   c, vout, $signed(iout), $signed(qout), sat, ei[c-1], eq[c-1], es[c-1]);
        end
        checks++;
        if (vout0 !== 1'b1 || iout0 !== 18'(wi[c-1]) || qout0 !== 18'(wq[c-1]) || sat0 !== 1'b0) begin
          errors++;
          $display("FAIL sat_off c=%0d: got v=%b i=%0d q=%0d s=%b, want v=1 i=%0d q=%0d s=0",
                   c, vout0, $signed(iout0), $signed(qout0), sat0, wi[c-1], wq[c-1]);
        end
      end
    end
    checks++;
    if (vout !== 1'b0 || sat !== 1'b0) begin
      errors++;
      $display("FAIL sat_strobe: got v=%b s=%b, want 0 0", vout, sat);
    end
  endtask

  task automatic test_gaps_sync();
    do_reset();
    dir = 1'b0; sync = 1'b0;
    en = 1'b1; iin = 18'd10; qin = 18'd20;
    step();
    checks++;
    if (vout !== 1'b0 || ph !== 2'd1) begin
      errors++;
      $display("FAIL gap_c0: got v=%b ph=%0d, want v=0 ph=1", vout, ph);
    end
    en = 1'b0;
    step();
    checks++;
    if (vout !== 1'b1 || iout !== 18'd10 || qout !== 18'd20) begin
      errors++;
      $display("FAIL gap_c1: got v=%b i=%0d q=%0d, want v=1 i=10 q=20", vout, $signed(iout), $signed(qout));
    end
    step();
    checks++;
    if (vout !== 1'b0 || iout !== 18'd10 || qout !== 18'd20 || ph !== 2'd1) begin
      errors++;
      $display("FAIL gap_hold: got v=%b i=%0d q=%0d ph=%0d, want v=0 i=10 q=20 ph=1",
               vout, $signed(iout), $signed(qout), ph);
    end
    en = 1'b1; sync = 1'b1; iin = 18'd30; qin = 18'd40;
    step();
    checks++;
    if (vout !== 1'b0 || ph !== 2'd1) begin
      errors++;
      $display("FAIL gap_sync: got v=%b ph=%0d, want v=0 ph=1", vout, ph);
    end
    en = 1'b0; sync = 1'b0;
    step();
    checks++;
    if (vout !== 1'b1 || iout !== 18'd30 || qout !== 18'd40) begin
      errors++;
      $display("FAIL gap_sync_out: got v=%b i=%0d q=%0d, want v=1 i=30 q=40", vout, $signed(iout), $signed(qout));
    end
    en = 1'b1; iin = 18'd1; qin = 18'd2;
    step();
    checks++;
    if (ph !== 2'd2) begin
      errors++;
      $display("FAIL idle_pre: got ph=%0d, want 2", ph);
    end
    en = 1'b0; sync = 1'b1;
    step();
    checks++;
    if (ph !== 2'd0 || vout !== 1'b1 || iout !== 18'd2 || qout !== 18'(-1)) begin
      errors++;
      $display("FAIL idle_sync: got ph=%0d v=%b i=%0d q=%0d, want ph=0 v=1 i=2 q=-1",
               ph, vout, $signed(iout), $signed(qout));
    end
    sync = 1'b0; en = 1'b1; iin = 18'd3; qin = 18'd4;
    step();
    checks++;
    if (vout !== 1'b0 || ph !== 2'd1) begin
      errors++;
      $display("FAIL idle_nout: got v=%b ph=%0d, want v=0 ph=1", vout, ph);
    end
    en = 1'b0;
    step();
    checks++;
    if (vout !== 1'b1 || iout !== 18'd3 || qout !== 18'd4) begin
      errors++;
      $display("FAIL idle_ph0: got v=%b i=%0d q=%0d, want v=1 i=3 q=4", vout, $signed(iout), $signed(qout));
    end
  endtask

  task automatic test_reset_flush();
    do_reset();
    dir = 1'b1; en = 1'b1; iin = 18'd50; qin = 18'd60;
    step();
    iin = 18'd70; qin = 18'd80;
    step();
    checks++;
    if (vout !== 1'b1 || iout !== 18'd50 || qout !== 18'd60) begin
      errors++;
      $display("FAIL flush_pre: got v=%b i=%0d q=%0d, want v=1 i=50 q=60", vout, $signed(iout), $signed(qout));
    end
    rst = 1'b1; en = 1'b1; sync = 1'b0;
    step();
    checks++;
    if ({iout, qout, vout, sat, ph} !== 40'd0) begin
      errors++;
      $display("FAIL flush_rst: got i=%h q=%h v=%b s=%b ph=%0d, want all 0", iout, qout, vout, sat, ph);
    end
    rst = 1'b0; en = 1'b0;
    step();
    checks++;
    if (vout !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop: got v=%b, want 0", vout);
    end
    en = 1'b1; iin = 18'd11; qin = 18'd22;
    step();
    en = 1'b0;
    step();
    checks++;
    if (vout !== 1'b1 || iout !== 18'd11 || qout !== 18'd22) begin
      errors++;
      $display("FAIL flush_ph0: got v=%b i=%0d q=%0d, want v=1 i=11 q=22", vout, $signed(iout), $signed(qout));
    end
  endtask

  task automatic model(input int i, input int q, input int p, input logic d, input logic sat_en,
                       output logic [17:0] io, output logic [17:0] qo, output logic s);
    int a, b, t;
    a = i; b = q; s = 1'b0;
    for (int k = 0; k < p; k++) begin
      t = a;
      if (d) begin a = -b; b = t; end
      else   begin a = b;  b = -t; end
    end
    if (sat_en && a > 131071) begin a = 131071; s = 1'b1; end
    if (sat_en && b > 131071) begin b = 131071; s = 1'b1; end
    io = 18'(a);
    qo = 18'(b);
  endtask

  function automatic logic [17:0] rnd_sample();
    case ($urandom_range(0, 7))
      0:       return 18'h20000;
      1:       return 18'h00000;
      2:       return 18'h1FFFF;
      default: return 18'($urandom);
    endcase
  endfunction

  task automatic test_random();
    int mn;
    int p;
    logic pv, cv;
    logic [17:0] pi, pq, pi0, pq0, ci_, cq_, ci0, cq0, li, lq, li0, lq0;
    logic ps, ps0, cs, cs0;
    do_reset();
    mn = 0; pv = 1'b0;
    pi = '0; pq = '0; pi0 = '0; pq0 = '0; ps = 1'b0; ps0 = 1'b0;
    li = '0; lq = '0; li0 = '0; lq0 = '0;
    ci_ = '0; cq_ = '0; ci0 = '0; cq0 = '0; cs = 1'b0; cs0 = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      en = ($urandom_range(0, 3) != 0);
      sync = ($urandom_range(0, 7) == 0);
      dir = 1'($urandom);
      iin = rnd_sample();
      qin = rnd_sample();
      cv = en;
      if (en) begin
        p = sync ? 0 : mn;
        model(int'($signed(iin)), int'($signed(qin)), p, dir, 1'b1, ci_, cq_, cs);
        model(int'($signed(iin)), int'($signed(qin)), p, dir, 1'b0, ci0, cq0, cs0);
        mn = (p + 1) % 4;
      end else if (sync) begin
        mn = 0;
      end
      step();
      if (pv) begin li = pi; lq = pq; li0 = pi0; lq0 = pq0; end
      checks++;
      if (vout !== pv || iout !== li || qout !== lq || sat !== (pv & ps) || ph !== 2'(mn)) begin
        errors++;
        $display("FAIL rand_sat1 c=%0d: got v=%b i=%h q=%h s=%b ph=%0d, want v=%b i=%h q=%h s=%b ph=%0d",
                 c, vout, iout, qout, sat, ph, pv, li, lq, pv & ps, mn);
      end
      checks++;
      if (vout0 !== pv || iout0 !== li0 || qout0 !== lq0 || sat0 !== 1'b0) begin
        errors++;
        $display("FAIL rand_sat0 c=%0d: got v=%b i=%h q=%h s=%b, want v=%b i=%h q=%h s=0",
                 c, vout0, iout0, qout0, sat0, pv, li0, lq0);
      end
      pv = cv; pi = ci_; pq = cq_; pi0 = ci0; pq0 = cq0; ps = cs; ps0 = cs0;
    end
    en = 1'b0; sync = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sync = 1'b0; dir = 1'b0; iin = '0; qin = '0;
    test_reset();
    test_mapping(1'b0);
    test_mapping(1'b1);
    test_saturation();
    test_gaps_sync();
    test_reset_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
